// File: rtl/pipe_reg_chain_if.sv
// Valid/ready stream interface for pipe_reg_chain: upstream accept side and downstream drain side.
// The chain itself connects through the slave modport; a producer/consumer pair uses master.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// WIDTH x DEPTH pipeline register with per-stage valid bits, valid/ready backpressure,
// bubble collapsing and synchronous flush. Stage DEPTH-1 drives the downstream side.
module pipe_reg_chain #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    pipe_reg_chain_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q     [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] stage_vld;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             accept;

    // A stage may advance when it is empty or everything downstream of it moves.
    always_comb begin : adv_chain
        logic carry;
        // NOTE: every variable written here gets a value on every path, so no latch is inferred.
        carry            = ~vld_q[DEPTH-1] | bus.out_ready;
        adv[DEPTH-1]     = carry;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            carry  = ~vld_q[i] | carry;
            adv[i] = carry;
        end
    end

    assign bus.in_ready = adv[0] & ~flush;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        stage_vld[0]  = accept;
        stage_data[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_vld[i]  = vld_q[i-1];
            stage_data[i] = data_q[i-1];
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            // NOTE: the data stages are reset too, because out_data must read RESET_VAL after reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    vld_q[i] <= stage_vld[i];
                    // Data is only replaced by a real word, so bubbles leave it untouched.
                    if (stage_vld[i]) begin
                        data_q[i] <= stage_data[i];
                    end
                end
            end
        end
    end

    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld_q[i]);
        end
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Drives one directed stimulus stream into three chain configurations at once and checks
// each against a token-queue model every cycle, plus hand-computed literal expectations.
module tb_pipe_reg_chain;
    localparam int NCFG = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // cfg0: WIDTH=16 DEPTH=2, cfg1: WIDTH=8 DEPTH=1, cfg2: WIDTH=8 DEPTH=4 RESET_VAL=0x5A
    pipe_reg_chain_if #(.WIDTH(16)) bus0 ();
    pipe_reg_chain_if #(.WIDTH(8))  bus1 ();
    pipe_reg_chain_if #(.WIDTH(8))  bus2 ();

    logic [1:0] occ0;
    logic       occ1;
    logic [2:0] occ2;

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data[7:0];
    assign bus1.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_data   = in_data[7:0];
    assign bus2.out_ready = out_ready;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(2), .RESET_VAL(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .occupancy(occ0)
    );
    pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .occupancy(occ1)
    );
    pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus2), .occupancy(occ2)
    );

    logic        act_valid [NCFG];
    logic [15:0] act_data  [NCFG];
    logic        act_ready [NCFG];
    logic [2:0]  act_occ   [NCFG];

    assign act_valid[0] = bus0.out_valid;
    assign act_data[0]  = bus0.out_data;
    assign act_ready[0] = bus0.in_ready;
    assign act_occ[0]   = {1'b0, occ0};
    assign act_valid[1] = bus1.out_valid;
    assign act_data[1]  = {8'h00, bus1.out_data};
    assign act_ready[1] = bus1.in_ready;
    assign act_occ[1]   = {2'b00, occ1};
    assign act_valid[2] = bus2.out_valid;
    assign act_data[2]  = {8'h00, bus2.out_data};
    assign act_ready[2] = bus2.in_ready;
    assign act_occ[2]   = occ2;

    function automatic int dep_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] msk_of(input int k);
        return (k == 0) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] rv_of(input int k);
        return (k == 2) ? 16'h005A : 16'h0000;
    endfunction

    // Model: ordered list of words (index 0 = oldest), each with the stage it sits in.
    logic [15:0] m_dat  [NCFG][4];
    int          m_pos  [NCFG][4];
    int          m_cnt  [NCFG];
    logic [15:0] m_last [NCFG];

    // Space exists unless every stage is full and nothing leaves.
    function automatic logic m_ready(input int k);
        return !flush && ((m_cnt[k] < dep_of(k)) || out_ready);
    endfunction

    function automatic logic m_valid(input int k);
        return (m_cnt[k] > 0) && (m_pos[k][0] == dep_of(k) - 1);
    endfunction

    task automatic model_step();
        for (int k = 0; k < NCFG; k++) begin
            int   d;
            int   lim;
            int   np;
            logic acc;
            d = dep_of(k);
            if (!rst) begin
                m_cnt[k]  = 0;
                m_last[k] = rv_of(k);
            end else begin
                acc = in_valid && m_ready(k);
                if (m_valid(k) && out_ready) begin
                    for (int j = 0; j < 3; j++) begin
                        m_dat[k][j] = m_dat[k][j+1];
                        m_pos[k][j] = m_pos[k][j+1];
                    end
                    m_cnt[k]--;
                end
                if (flush) begin
                    m_cnt[k] = 0;
                end else begin
                    // Each word steps one stage forward unless it would run into the word ahead.
                    lim = d - 1;
                    for (int j = 0; j < m_cnt[k]; j++) begin
                        np = (m_pos[k][j] + 1 < lim) ? m_pos[k][j] + 1 : lim;
                        if (np == d - 1 && m_pos[k][j] != d - 1) m_last[k] = m_dat[k][j];
                        m_pos[k][j] = np;
                        lim = np - 1;
                    end
                    if (acc) begin
                        m_dat[k][m_cnt[k]] = in_data & msk_of(k);
                        m_pos[k][m_cnt[k]] = 0;
                        m_cnt[k]++;
                        if (d == 1) m_last[k] = in_data & msk_of(k);
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < NCFG; k++) begin
                    check($sformatf("cfg%0d out_valid", k), 32'(act_valid[k]), 32'(m_valid(k)));
                    check($sformatf("cfg%0d out_data", k), 32'(act_data[k]), 32'(m_last[k]));
                    check($sformatf("cfg%0d in_ready", k), 32'(act_ready[k]), 32'(m_ready(k)));
                    check($sformatf("cfg%0d occupancy", k), 32'(act_occ[k]), 32'(m_cnt[k]));
                end
            end
        end
    end

    // Inputs change just after the rising edge and hold until the next one.
    task automatic drive(input logic iv, input logic [15:0] d, input logic ordy,
                         input logic fl, input logic rs);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset for two edges, then release.
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset out_valid", 32'(bus0.out_valid), 32'd0);
        check("reset out_data", 32'(bus0.out_data), 32'h0000);
        check("reset occupancy", 32'(occ0), 32'd0);
        check("reset in_ready", 32'(bus0.in_ready), 32'd1);
        check("reset cfg2 out_data", 32'(bus2.out_data), 32'h5A);

        // Streaming 0x0001..0x0010 with downstream always ready.
        drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("stream first in stage0", 32'(bus0.out_valid), 32'd0);
        check("stream cfg1 next-cycle data", 32'(bus1.out_data), 32'h01);
        drive(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("stream latency valid", 32'(bus0.out_valid), 32'd1);
        check("stream latency data", 32'(bus0.out_data), 32'h0001);
        check("stream occupancy", 32'(occ0), 32'd2);
        check("model stream occupancy", 32'(m_cnt[0]), 32'd2);
        for (int w = 4; w <= 16; w++) drive(1'b1, 16'(w), 1'b1, 1'b0, 1'b1);
        idle(6);
        @(negedge clk);
        check("stream drained data held", 32'(bus0.out_data), 32'h0010);
        check("stream cfg2 last data", 32'(bus2.out_data), 32'h10);

        // Backpressure: three words offered with downstream stalled.
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("stall occupancy", 32'(occ0), 32'd2);
        check("stall in_ready", 32'(bus0.in_ready), 32'd0);
        check("stall out_data", 32'(bus0.out_data), 32'hAAAA);
        check("stall cfg1 out_data", 32'(bus1.out_data), 32'hAA);
        check("stall cfg1 in_ready", 32'(bus1.in_ready), 32'd0);
        check("stall cfg2 occupancy", 32'(occ2), 32'd2);
        check("model stall cfg2 valid", 32'(m_valid(2)), 32'd0);
        drive(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("full+ready in_ready", 32'(bus0.in_ready), 32'd1);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("release out_data", 32'(bus0.out_data), 32'hBBBB);
        check("release occupancy", 32'(occ0), 32'd2);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("release third word", 32'(bus0.out_data), 32'hCCCC);
        idle(6);

        // Simultaneous drain and accept on a full chain.
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h3333, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("swap in_ready", 32'(bus0.in_ready), 32'd1);
        check("swap out_data before", 32'(bus0.out_data), 32'h1111);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("swap occupancy", 32'(occ0), 32'd2);
        check("swap out_data after", 32'(bus0.out_data), 32'h2222);
        idle(6);

        // Flush with a word on offer.
        drive(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h6666, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h7777, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("flush in_ready cfg0", 32'(bus0.in_ready), 32'd0);
        check("flush in_ready cfg2", 32'(bus2.in_ready), 32'd0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("flush out_valid", 32'(bus0.out_valid), 32'd0);
        check("flush occupancy", 32'(occ0), 32'd0);
        check("flush data held", 32'(bus0.out_data), 32'h5555);
        idle(6);

        // Flush coinciding with a drain handshake.
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h4321, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        idle(6);

        // Reset in the middle of a full chain.
        drive(1'b1, 16'h8888, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h9999, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("midreset out_valid", 32'(bus0.out_valid), 32'd0);
        check("midreset occupancy", 32'(occ0), 32'd0);
        check("midreset out_data", 32'(bus0.out_data), 32'h0000);
        check("midreset in_ready", 32'(bus0.in_ready), 32'd1);
        check("midreset cfg2 out_data", 32'(bus2.out_data), 32'h5A);

        // Short stream after reset to show normal operation resumes.
        for (int w = 0; w < 5; w++) drive(1'b1, 16'h0021 + 16'(w), 1'b1, 1'b0, 1'b1);
        idle(6);
        @(negedge clk);
        check("post-reset last word", 32'(bus0.out_data), 32'h0025);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
